// File: rtl/sqg_qpow_acc.sv
// Sweeps the box-count RAM, raises each count to moment order q and accumulates Z(q) = sum x^q.
// Build option: define SQG_QPOW_SAT_EN for saturating accumulator/write-back with sticky ovf.
module sqg_qpow_acc #(
   parameter int DW   = 8,
   parameter int AW   = 6,
   parameter int QMAX = 4,
   parameter int ACCW = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start_i,
   input  logic [2:0]      q_i,
   input  logic            wb_i,
   output logic [AW-1:0]   rd_addr_o,
   output logic            rd_en_o,
   input  logic [DW-1:0]   rd_data_i,
   output logic [AW-1:0]   wr_addr_o,
   output logic [DW-1:0]   wr_data_o,
   output logic            wen_o,
   output logic [ACCW-1:0] sum_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic            ovf_o
);

   localparam int PW   = DW * QMAX;
   localparam int EXTW = ((ACCW > PW) ? ACCW : PW) + 1;
   localparam logic [2:0]      QMAX_Q  = 3'(QMAX);
   localparam logic [EXTW-1:0] ACC_MAX = EXTW'({ACCW{1'b1}});
   localparam logic [PW-1:0]   DAT_MAX = PW'({DW{1'b1}});

   typedef enum logic [2:0] {S_IDLE, S_RD, S_LD, S_MUL, S_ACC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [2:0]      q_q, q_d;
   logic            wb_q, wb_d;
   logic [DW-1:0]   base_q, base_d;
   logic [PW-1:0]   pw_q, pw_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [ACCW-1:0] sum_q, sum_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;

   logic [EXTW-1:0] acc_ext;
   logic [DW-1:0]   wr_red;
   logic            acc_sat, wr_sat;

   assign acc_ext = EXTW'(acc_q) + EXTW'(pw_q);

`ifdef SQG_QPOW_SAT_EN
   assign acc_sat = (acc_ext > ACC_MAX);
   assign wr_sat  = (pw_q > DAT_MAX);
   assign wr_red  = wr_sat ? {DW{1'b1}} : pw_q[DW-1:0];
`else
   assign acc_sat = 1'b0;
   assign wr_sat  = 1'b0;
   assign wr_red  = pw_q[DW-1:0];
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      q_d     = q_q;
      wb_d    = wb_q;
      base_d  = base_q;
      pw_d    = pw_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (q_i <= QMAX_Q) begin
                  state_d = S_RD;
                  q_d     = q_i;
                  wb_d    = wb_i;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  addr_d  = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RD: state_d = S_LD;
         S_LD: begin
            base_d = rd_data_i;
            cnt_d  = q_q - 3'd1;
            // empty boxes contribute 0 regardless of q, including q=0
            if (rd_data_i == '0)  pw_d = '0;
            else if (q_q == 3'd0) pw_d = PW'(1);
            else                  pw_d = PW'(rd_data_i);
            if (q_q >= 3'd2 && rd_data_i != '0) state_d = S_MUL;
            else                                state_d = S_ACC;
         end
         S_MUL: begin
            pw_d  = pw_q * PW'(base_q);
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = S_ACC;
         end
         S_ACC: begin
            acc_d = acc_sat ? {ACCW{1'b1}} : acc_ext[ACCW-1:0];
            if (acc_sat || (wb_q && wr_sat)) ovf_d = 1'b1;
            if (addr_q == {AW{1'b1}}) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = S_RD;
            end
         end
         S_DONE: begin
            sum_d   = acc_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         q_q     <= '0;
         wb_q    <= 1'b0;
         base_q  <= '0;
         pw_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         q_q     <= q_d;
         wb_q    <= wb_d;
         base_q  <= base_d;
         pw_q    <= pw_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rd_en_o   = (state_q == S_RD);
   assign rd_addr_o = addr_q;
   assign wen_o     = (state_q == S_ACC) && wb_q;
   assign wr_addr_o = addr_q;
   assign wr_data_o = wen_o ? wr_red : '0;
   assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign sum_o     = sum_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_sqg_qpow_acc.sv
// Directed bench for sqg_qpow_acc: behavioural box-count RAM plus hand-computed partition sums.
module tb_sqg_qpow_acc;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  q_i = 3'd0;
   logic        wb_i = 1'b0;
   logic [5:0]  rd_addr_o;
   logic        rd_en_o;
   logic [7:0]  rd_data_i = 8'd0;
   logic [5:0]  wr_addr_o;
   logic [7:0]  wr_data_o;
   logic        wen_o;
   logic [31:0] sum_o;
   logic        busy_o, done_o, err_o, ovf_o;

   sqg_qpow_acc dut (
      .CLK(CLK), .RST(RST), .start_i(start_i), .q_i(q_i), .wb_i(wb_i),
      .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i),
      .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wen_o(wen_o),
      .sum_o(sum_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o)
   );

   always #5 CLK = ~CLK;

   logic [7:0] mem [64];
   int vectors = 0;
   int miscompares = 0;
   int wen_cnt, rd_cnt, addr_bad, wdat_bad, both_bad;
   int exp_addr;
   int cur_q;
   logic [7:0] last_wdat;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [7:0] wr_ref(input logic [7:0] x, input int qq);
      logic [63:0] p;
      p = 64'd1;
      if (x == 8'd0) return 8'd0;
      for (int k = 0; k < qq; k++) p = p * 64'(x);
`ifdef SQG_QPOW_SAT_EN
      return (p > 64'd255) ? 8'd255 : p[7:0];
`else
      return p[7:0];
`endif
   endfunction

   always @(posedge CLK) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

   always @(negedge CLK) begin
      if (rd_en_o) rd_cnt++;
      if (wen_o && rd_en_o) both_bad++;
      if (wen_o) begin
         wen_cnt++;
         if (int'(wr_addr_o) != exp_addr) addr_bad++;
         if (wr_data_o != wr_ref(mem[wr_addr_o], cur_q)) wdat_bad++;
         last_wdat = wr_data_o;
         exp_addr++;
      end
   end

   task automatic clr_counts();
      wen_cnt = 0; rd_cnt = 0; addr_bad = 0; wdat_bad = 0; both_bad = 0; exp_addr = 0;
   endtask

   task automatic run_sweep(input int qq, input logic wb, output int cyc);
      bit seen;
      clr_counts();
      cur_q = qq;
      @(negedge CLK);
      start_i = 1'b1; q_i = 3'(qq); wb_i = wb;
      @(posedge CLK); #1;
      start_i = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 2000) begin
         @(posedge CLK); #1;
         cyc++;
         if (done_o) seen = 1;
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_sum"}, sum_o, 0);
      check({tag, "_addr"}, {rd_addr_o, wr_addr_o, wr_data_o}, 0);
      check({tag, "_flags"}, {busy_o, done_o, err_o, ovf_o, wen_o, rd_en_o}, 0);
   endtask

   initial begin
      int cyc;
      bit found;
      clr_counts();
      cur_q = 0;
      for (int i = 0; i < 64; i++) mem[i] = 8'd16;
      #12;
      check_reset_outs("reset");
      @(negedge CLK) RST = 1'b1;

      // 1: all 16, q=2, write-back
      run_sweep(2, 1'b1, cyc);
      check("t1_sum", sum_o, 16384);
      check("t1_wen_cnt", wen_cnt, 64);
      check("t1_wr_addr", addr_bad, 0);
      check("t1_wr_data_all", wdat_bad, 0);
      check("t1_rd_wen_overlap", both_bad, 0);
`ifdef SQG_QPOW_SAT_EN
      check("t1_wr_data", last_wdat, 255);
      check("t1_ovf", ovf_o, 1);
`else
      check("t1_wr_data", last_wdat, 0);
      check("t1_ovf", ovf_o, 0);
`endif

      // 2: all 30, q=2, no write-back; timing
      for (int i = 0; i < 64; i++) mem[i] = 8'd30;
      run_sweep(2, 1'b0, cyc);
      check("t2_sum", sum_o, 57600);
      check("t2_done_latency", cyc, 257);
      check("t2_wen_cnt", wen_cnt, 0);
      check("t2_rd_cnt", rd_cnt, 64);
      check("t2_ovf", ovf_o, 0);
      @(posedge CLK); #1;
      check("t2_done_pulse", done_o, 0);

      // 3: even boxes 5, odd boxes 0
      for (int i = 0; i < 64; i++) mem[i] = (i % 2 == 0) ? 8'd5 : 8'd0;
      run_sweep(0, 1'b1, cyc);
      check("t3_q0_sum", sum_o, 32);
      check("t3_q0_wen_cnt", wen_cnt, 64);
      check("t3_q0_wr_data", wdat_bad, 0);
      check("t3_q0_done_latency", cyc, 193);
      run_sweep(3, 1'b1, cyc);
      check("t3_q3_sum", sum_o, 4000);
      check("t3_q3_wr_data", wdat_bad, 0);
      check("t3_q3_ovf", ovf_o, 0);

      // 4: illegal q rejected
      clr_counts();
      @(negedge CLK);
      start_i = 1'b1; q_i = 3'd5; wb_i = 1'b1;
      @(posedge CLK); #1;
      start_i = 1'b0;
      check("t4_err", err_o, 1);
      check("t4_busy", busy_o, 0);
      @(posedge CLK); #1;
      check("t4_err_pulse", err_o, 0);
      repeat (3) @(posedge CLK);
      #1;
      check("t4_rd_cnt", rd_cnt, 0);
      check("t4_sum", sum_o, 4000);

      // 5: all 255, q=4
      for (int i = 0; i < 64; i++) mem[i] = 8'd255;
      run_sweep(4, 1'b0, cyc);
`ifdef SQG_QPOW_SAT_EN
      check("t5_sum", sum_o, 32'hFFFFFFFF);
      check("t5_ovf", ovf_o, 1);
`else
      check("t5_sum", sum_o, 25100352);
      check("t5_ovf", ovf_o, 0);
`endif

      // 6: reset during box 20 multiply, then a clean sweep
      for (int i = 0; i < 64; i++) mem[i] = 8'd16;
      clr_counts();
      cur_q = 2;
      @(negedge CLK);
      start_i = 1'b1; q_i = 3'd2; wb_i = 1'b1;
      @(posedge CLK); #1;
      start_i = 1'b0;
      found = 0;
      for (int c = 0; c < 500 && !found; c++) begin
         if (rd_en_o && rd_addr_o == 6'd20) found = 1;
         else begin @(posedge CLK); #1; end
      end
      check("t6_reached_box20", found, 1);
      @(posedge CLK);
      @(posedge CLK);
      #2;
      check("t6_busy_before_reset", busy_o, 1);
      RST = 1'b0;
      #1;
      check_reset_outs("t6_async_reset");
      @(negedge CLK) RST = 1'b1;
      run_sweep(2, 1'b1, cyc);
      check("t6_sum", sum_o, 16384);
      check("t6_wen_cnt", wen_cnt, 64);
      check("t6_wr_addr", addr_bad, 0);
      check("t6_wr_data_all", wdat_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
